// File: rtl/bus_pkg.sv
// Shared definitions for the shared-bus requester: FSM state encoding and the default beat timeout.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    localparam int TMO_DEFAULT = 15;
    localparam int WAIT_W      = 8;

endpackage

// File: rtl/arb_requester.sv
// Arbitrated shared-bus master: one command -> 1..4 beats; response pulses one cycle after each beat's ack.
// Backpressure: cmd_ready only in IDLE; the bus stalls on a dropped grant and frees itself after TMO cycles without ack.
module arb_requester
    import bus_pkg::*;
#(
    parameter int AW  = 16,
    parameter int DW  = 8,
    parameter int TMO = TMO_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [1:0]    cmd_len,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          arb_req,
    input  logic          arb_gnt,
    output logic          bus_en,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ack
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TMO - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_we;
    logic [AW-1:0]       r_addr;
    logic [DW-1:0]       r_wdata;
    logic [1:0]          r_last;
    logic [1:0]          r_beat;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [DW-1:0]       r_rsp_rdata;

    logic                w_cmd_ready;
    logic                w_arb_req;
    logic                w_accept;
    logic                w_bus_en;
    logic                w_beat_done;
    logic                w_timeout;
    logic [AW-1:0]       w_beat_addr;

    // The grant gates the bus directly so a dropped grant releases it in the same cycle.
    assign w_bus_en    = (r_state == ST_XFER) && arb_gnt;
    assign w_beat_done = w_bus_en && bus_ack;
    assign w_timeout   = w_bus_en && !bus_ack && (r_wait == WAIT_LAST);
    assign w_accept    = cmd_valid && w_cmd_ready;
    assign w_beat_addr = r_addr + AW'(r_beat);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_arb_req   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = !reset;
                if (cmd_valid && !reset) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                w_arb_req = 1'b1;
                if (arb_gnt) begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                w_arb_req = 1'b1;
                if ((w_beat_done && (r_beat == r_last)) || w_timeout) begin
                    w_state_nxt = ST_REL;
                end
            end
            ST_REL: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_last      <= 2'd0;
            r_beat      <= 2'd0;
            r_wait      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_beat_done || w_timeout;
            r_rsp_err   <= w_timeout;
            r_rsp_rdata <= (w_beat_done && !r_we) ? bus_rdata : '0;
            if (w_accept) begin
                r_we    <= cmd_we;
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
                r_last  <= cmd_we ? 2'd0 : cmd_len;
                r_beat  <= 2'd0;
                r_wait  <= '0;
            end else if (w_beat_done) begin
                r_beat <= r_beat + 2'd1;
                r_wait <= '0;
            end else if (w_bus_en) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
        end
    end

    assign cmd_ready = w_cmd_ready;
    assign arb_req   = w_arb_req;
    assign bus_en    = w_bus_en;
    assign bus_we    = w_bus_en && r_we;
    assign bus_addr  = w_bus_en ? w_beat_addr : '0;
    assign bus_wdata = w_bus_en ? r_wdata : '0;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter AW, default 16, bus address width.
REQ-002 Parameter DW, default 8, bus data width.
REQ-003 Parameter TMO, default 15, max cycles waiting for bus_ack per beat (1..255).
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  local command offered.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-008 cmd_we  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  AW  first beat address.
REQ-010 cmd_wdata  in  DW  write data.
REQ-011 cmd_len  in  2  read beats minus one (1..4 beats); ignored for writes.
REQ-012 rsp_valid  out  1  one-cycle pulse per completed beat.
REQ-013 rsp_rdata  out  DW  read data, 0 for writes.
REQ-014 rsp_err  out  1  qualifies rsp_valid; beat timed out.
REQ-015 arb_req  out  1  request line to the shared-bus arbiter slice.
REQ-016 arb_gnt  in  1  grant from arbiter; may drop at any cycle.
REQ-017 bus_en  out  1  drives the shared bus this cycle.
REQ-018 bus_we, bus_addr, bus_wdata  out  1/AW/DW  bus command; 0 when bus_en low.
REQ-019 bus_rdata, bus_ack  in  DW/1  slave data and per-beat acknowledge.

Function
REQ-020 FSM states IDLE, REQ, XFER, REL; registered.
REQ-021 cmd_ready = 1 only in IDLE; accepting latches we, addr, wdata, beats (writes force 1 beat), IDLE->REQ.
REQ-022 arb_req = 1 in REQ and XFER, 0 in IDLE and REL.
REQ-023 REQ: arb_gnt high -> XFER next cycle; otherwise hold REQ indefinitely.
REQ-024 XFER: bus_en = arb_gnt (combinational gate); bus_addr = latched addr + beat index, wrapping modulo 2^AW.
REQ-025 Beat completes when bus_en & bus_ack in the same cycle; next cycle rsp_valid=1, rsp_err=0, rsp_rdata = sampled bus_rdata (read) or 0 (write).
REQ-026 arb_gnt low in XFER: bus_en low, beat not counted, wait counter frozen, arb_req held; beat resumes on regrant.
REQ-027 Wait counter (8 bit) clears at each beat start, increments each cycle bus_en high without bus_ack; reaching TMO emits rsp_valid=1, rsp_err=1 for that beat, remaining beats abandoned, -> REL.
REQ-028 Last beat completed (or timeout) -> REL; REL lasts exactly one cycle with arb_req=0, then IDLE, so the arbiter can rotate priority.
REQ-029 Exactly one rsp_valid per issued beat up to and including an errored beat; never more than one per cycle.
REQ-030 bus_ack while bus_en low is ignored.

Reset
REQ-031 reset high: state IDLE, beat index 0, counter 0, all outputs 0 except cmd_ready=1 the cycle after reset deasserts.
REQ-032 reset mid-XFER: bus_en and arb_req 0 the next cycle, no rsp_valid emitted for the aborted beat.

Structure
REQ-033 State enum and default TMO constant live in shared package bus_pkg.
REQ-034 Single module; no sub-module required (wait counter inline).

Verification
REQ-035 Read len=3, addr 0x00FE, gnt immediate, ack 1 cycle after bus_en -> 4 rsp_valid, bus_addr 00FE,00FF,0100,0101, then one REL cycle with arb_req=0.
REQ-036 Write addr 0x1234 data 0xA5, cmd_len=3 -> single beat, bus_we=1, rsp_valid once with rsp_rdata=0.
REQ-037 Grant withheld 10 cycles -> arb_req stays 1, bus_en 0, no rsp_valid; then grant -> normal completion.
REQ-038 Read len=1, grant drops 3 cycles mid-beat 0 -> bus_en low those cycles, counter frozen, both beats complete, no error.
REQ-039 TMO=15, no ack -> rsp_err pulse after 15 bus_en cycles, remaining beats skipped, REL, IDLE.
REQ-040 Address 0xFFFF read len=1 -> second beat at 0x0000; reset asserted during XFER -> bus_en/arb_req 0 next cycle.
